mmu_bytelane_ram: RTL and testbench
===================================

Name: mmu_bytelane_ram

Overview:
- Parametrised byte-lane memory unit for the pipelined Subleq core; generalises the fixed 64-bit, 8-lane MMU.
- Port A: one read/write port with active-low per-byte write enables.
- Port B: second read-only port, so the pipeline can fetch both operands in one cycle.
- Adds alignment/range checking, A-to-B write forwarding, and a hardware memory-clear sequencer run after every reset.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of 8, min 8.
- ADDR_WIDTH, 16, byte-address width of both ports.
- DEPTH, 256, number of words; power of two, DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every location during the clear sequence.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  port A request strobe.
- we  in  1  port A write when 1, read when 0; qualified by en.
- ben_n  in  DATA_WIDTH/8  active-low byte enables for port A writes; bit i selects byte lane i (bits 8i+7:8i).
- addr  in  ADDR_WIDTH  port A byte address.
- data_in  in  DATA_WIDTH  port A write data.
- b_en  in  1  port B read strobe.
- b_addr  in  ADDR_WIDTH  port B byte address.
- data_out  out  DATA_WIDTH  port A read data, registered.
- valid  out  1  port A response valid, one-cycle pulse.
- err  out  1  port A misaligned or out-of-range, pulses with valid.
- b_data_out  out  DATA_WIDTH  port B read data, registered.
- b_valid  out  1  port B response valid, one-cycle pulse.
- b_err  out  1  port B misaligned or out-of-range, pulses with b_valid.
- busy  out  1  clear sequence running; all requests are ignored.

Behaviour:
- Reset values, in the cycle after reset is sampled high:
  - data_out = 0, b_data_out = 0
  - valid = 0, b_valid = 0, err = 0, b_err = 0
  - busy = 1
  - clear pointer = 0
- Address decode:
  - NB = DATA_WIDTH/8, LB = log2(NB).
  - Word index = addr[ADDR_WIDTH-1:LB].
  - Misaligned: addr[LB-1:0] != 0 (never misaligned when NB = 1).
  - Out of range: word index >= DEPTH.
- States:
  - CLEAR:
    - Writes CLEAR_VALUE to word ptr each cycle, ptr increments.
    - After word DEPTH-1 is written, go to RUN next cycle; busy = 1 for exactly DEPTH cycles after reset deasserts.
    - en and b_en are ignored; no valid or b_valid pulses.
  - RUN:
    - busy = 0; requests are accepted every cycle, with no backpressure.
    - Reset asserted in any state, including mid-clear, returns to CLEAR with ptr = 0; the clear restarts from word 0.
- Port A latency is 1 cycle: request sampled at edge N, valid = 1 after edge N, for one cycle.
  - Read, good address: data_out = mem[idx].
  - Write, good address:
    - For each lane i with ben_n[i] = 0, mem byte i = data_in byte i; other lanes unchanged.
    - data_out = merged new word (write-through echo).
    - A write with all ben_n = 1 changes nothing and still responds valid.
  - Bad address: err = 1, data_out = 0, memory not modified.
- Port B latency is 1 cycle, same timing.
  - Good address: b_data_out = mem[b_idx].
  - Bad address: b_err = 1, b_data_out = 0.
- Simultaneous A write and B read to the same word index in the same cycle: b_data_out returns the post-write merged word (forwarding).
- Simultaneous A read and B read to any addresses: both served independently.
- data_out and b_data_out hold their value when no request is made; valid, b_valid, err and b_err return to 0.
- Contents persist across RUN cycles and are only reinitialised by the clear sequence.

Test Plan:
- Clear: pulse reset 1 cycle -> busy = 1 for exactly DEPTH (256) cycles, then 0. Port B read of 0x0, 0x8 and 0x7F8 returns 0 with b_valid = 1. en = 1 during busy -> no valid pulse.
- Full-lane writes: ben_n = 8'h00, addr = i*8 for i = 0..15, data_in = 64'hDEADBEEFBAADC0DE -> valid each following cycle, data_out echoes the word. Readback of all 16 words returns 64'hDEADBEEFBAADC0DE.
- Byte lanes: on word 0x10 holding 64'hDEADBEEFBAADC0DE, write ben_n = 8'hF0, data_in = 64'h1122334455667788 -> read 64'hDEADBEEF55667788. Then ben_n = 8'hFF -> word unchanged, valid = 1.
- Errors:
  - addr = 0x0003 -> err = 1, data_out = 0, no memory change.
  - addr = 0x0800 (idx 256) -> err = 1.
  - b_addr = 0x0805 -> b_err = 1.
- Forwarding: same cycle, A writes 0x20 with 64'hCAFEF00D12345678 (ben_n = 0) and B reads 0x20 -> b_data_out = 64'hCAFEF00D12345678 one cycle later.
- Reset mid-operation:
  - Assert reset during a write burst -> next cycle valid = 0, busy = 1; the clear reruns fully and prior data reads 0.
  - Assert reset at clear ptr = 100 -> busy lasts 256 more cycles.

Source files
------------

// File: rtl/mmu_bytelane_ram_if.sv
// Request/response bundle for the byte-lane memory: port A read/write,
// port B read-only, plus the clear-sequencer busy flag.
interface mmu_bytelane_ram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16
);
    logic                      en;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   ben_n;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      b_en;
    logic [ADDR_WIDTH-1:0]     b_addr;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      valid;
    logic                      err;
    logic [DATA_WIDTH-1:0]     b_data_out;
    logic                      b_valid;
    logic                      b_err;
    logic                      busy;

    modport master (
        output en, we, ben_n, addr, data_in, b_en, b_addr,
        input  data_out, valid, err, b_data_out, b_valid, b_err, busy
    );

    modport slave (
        input  en, we, ben_n, addr, data_in, b_en, b_addr,
        output data_out, valid, err, b_data_out, b_valid, b_err, busy
    );
endinterface

// File: rtl/mmu_bytelane_ram.sv
// Dual-port byte-lane RAM with range/alignment checks, A-to-B write
// forwarding and a post-reset clear sequencer.
module mmu_bytelane_ram #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic               clk,
    input logic               reset,
    mmu_bytelane_ram_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << LB) - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IW-1:0]         LAST_PTR = IW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_e;

    // Widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] widx;
        widx = {1'b0, (a >> LB)};
        return (|(a & LOW_MASK)) || (widx >= DEPTH_W);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] s;
        s = a >> LB;
        return s[IW-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] b_data_out_q, b_data_out_d;
    logic                  b_valid_q, b_valid_d;
    logic                  b_err_q, b_err_d;

    logic                  mem_we;
    logic [IW-1:0]         mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  a_go, a_bad, a_wr;
    logic                  b_go, b_bad;
    logic [IW-1:0]         a_idx, b_idx;
    logic [DATA_WIDTH-1:0] a_rd, b_rd, merged;

    always_comb begin
        a_idx  = word_idx(bus.addr);
        b_idx  = word_idx(bus.b_addr);
        a_bad  = addr_bad(bus.addr);
        b_bad  = addr_bad(bus.b_addr);
        a_go   = (state_q == S_RUN) && bus.en;
        b_go   = (state_q == S_RUN) && bus.b_en;
        a_wr   = a_go && bus.we && !a_bad;
        a_rd   = mem_q[a_idx];
        b_rd   = mem_q[b_idx];
        merged = a_rd;
        for (int i = 0; i < NB; i++) begin
            if (!bus.ben_n[i]) begin
                merged[8*i +: 8] = bus.data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        b_data_out_d = b_data_out_q;
        b_valid_d    = 1'b0;
        b_err_d      = 1'b0;
        mem_we       = 1'b0;
        mem_widx     = a_idx;
        mem_wdata    = merged;

        unique case (state_q)
            S_CLEAR: begin
                mem_we    = !reset;
                mem_widx  = ptr_q;
                mem_wdata = CLEAR_VALUE;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_we = a_wr && !reset;
                if (a_go) begin
                    valid_d = 1'b1;
                    if (a_bad) begin
                        err_d      = 1'b1;
                        data_out_d = '0;
                    end else begin
                        data_out_d = bus.we ? merged : a_rd;
                    end
                end
                if (b_go) begin
                    b_valid_d = 1'b1;
                    if (b_bad) begin
                        b_err_d      = 1'b1;
                        b_data_out_d = '0;
                    end else if (a_wr && (a_idx == b_idx)) begin
                        b_data_out_d = merged;
                    end else begin
                        b_data_out_d = b_rd;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            b_data_out_q <= '0;
            b_valid_q    <= 1'b0;
            b_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            b_data_out_q <= b_data_out_d;
            b_valid_q    <= b_valid_d;
            b_err_q      <= b_err_d;
        end
    end

    // Storage is never reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid      = valid_q;
    assign bus.err        = err_q;
    assign bus.b_data_out = b_data_out_q;
    assign bus.b_valid    = b_valid_q;
    assign bus.b_err      = b_err_q;
    assign bus.busy       = (state_q == S_CLEAR);
endmodule

// File: tb/tb_mmu_bytelane_ram.sv
// Directed bench for mmu_bytelane_ram: clear timing, lane writes,
// error decode, forwarding and reset during operation.
module tb_mmu_bytelane_ram;
    localparam logic [63:0] W_A = 64'hDEADBEEFBAADC0DE;
    localparam logic [63:0] W_B = 64'h1122334455667788;
    localparam logic [63:0] W_M = 64'hDEADBEEF55667788;
    localparam logic [63:0] W_F = 64'hCAFEF00D12345678;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mmu_bytelane_ram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) bus ();

    mmu_bytelane_ram #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(16),
        .DEPTH(256),
        .CLEAR_VALUE(64'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.en     = 1'b0;
        bus.we     = 1'b0;
        bus.ben_n  = 8'hFF;
        bus.addr   = '0;
        bus.data_in = '0;
        bus.b_en   = 1'b0;
        bus.b_addr = '0;
    endtask

    task automatic count_busy(output int cycles, output int pulses);
        cycles = 0;
        pulses = 0;
        while (bus.busy && cycles < 1000) begin
            tick();
            cycles++;
            if (bus.valid || bus.b_valid) pulses++;
        end
    endtask

    task automatic test_reset();
        int cyc, pul;
        idle();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.b_valid !== 1'b0 ||
            bus.err !== 1'b0 || bus.b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b bv=%b e=%b be=%b want 0000",
                     bus.valid, bus.b_valid, bus.err, bus.b_err);
        end
        checks++;
        if (bus.data_out !== 64'h0 || bus.b_data_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h want 0 0",
                     bus.data_out, bus.b_data_out);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got %b want 1", bus.busy);
        end
        reset = 1'b0;
        bus.en = 1'b1;
        bus.b_en = 1'b1;
        count_busy(cyc, pul);
        idle();
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL clear_len got %0d want 256", cyc);
        end
        checks++;
        if (pul != 0) begin
            errors++;
            $display("FAIL clear_ignore got %0d pulses want 0", pul);
        end
    endtask

    task automatic test_clear_read();
        logic [15:0] addrs [3];
        addrs[0] = 16'h0000;
        addrs[1] = 16'h0008;
        addrs[2] = 16'h07F8;
        for (int i = 0; i < 3; i++) begin
            bus.b_en   = 1'b1;
            bus.b_addr = addrs[i];
            tick();
            checks++;
            if (bus.b_valid !== 1'b1 || bus.b_err !== 1'b0 ||
                bus.b_data_out !== 64'h0) begin
                errors++;
                $display("FAIL clear_read[%h] got v=%b e=%b d=%h want 1 0 0",
                         addrs[i], bus.b_valid, bus.b_err, bus.b_data_out);
            end
        end
        idle();
    endtask

    task automatic test_full_lane();
        for (int i = 0; i < 16; i++) begin
            bus.en = 1'b1;
            bus.we = 1'b1;
            bus.ben_n = 8'h00;
            bus.addr = 16'(i * 8);
            bus.data_in = W_A;
            tick();
            checks++;
            if (bus.valid !== 1'b1 || bus.err !== 1'b0 ||
                bus.data_out !== W_A) begin
                errors++;
                $display("FAIL full_write[%0d] got v=%b e=%b d=%h want 1 0 %h",
                         i, bus.valid, bus.err, bus.data_out, W_A);
            end
        end
        for (int i = 0; i < 16; i++) begin
            bus.en = 1'b1;
            bus.we = 1'b0;
            bus.ben_n = 8'hFF;
            bus.addr = 16'(i * 8);
            bus.b_en = 1'b1;
            bus.b_addr = 16'((15 - i) * 8);
            tick();
            checks++;
            if (bus.data_out !== W_A || bus.b_data_out !== W_A ||
                bus.valid !== 1'b1 || bus.b_valid !== 1'b1) begin
                errors++;
                $display("FAIL full_read[%0d] got a=%h b=%h want %h",
                         i, bus.data_out, bus.b_data_out, W_A);
            end
        end
        idle();
    endtask

    task automatic test_byte_lanes();
        bus.en = 1'b1;
        bus.we = 1'b1;
        bus.ben_n = 8'hF0;
        bus.addr = 16'h0010;
        bus.data_in = W_B;
        tick();
        checks++;
        if (bus.data_out !== W_M) begin
            errors++;
            $display("FAIL lane_echo got %h want %h", bus.data_out, W_M);
        end
        bus.ben_n = 8'hFF;
        bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== W_M) begin
            errors++;
            $display("FAIL lane_none got v=%b d=%h want 1 %h",
                     bus.valid, bus.data_out, W_M);
        end
        bus.we = 1'b0;
        tick();
        checks++;
        if (bus.data_out !== W_M) begin
            errors++;
            $display("FAIL lane_read got %h want %h", bus.data_out, W_M);
        end
        idle();
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.data_out !== W_M) begin
            errors++;
            $display("FAIL hold got v=%b d=%h want 0 %h",
                     bus.valid, bus.data_out, W_M);
        end
    endtask

    task automatic test_errors();
        bus.en = 1'b1;
        bus.we = 1'b1;
        bus.ben_n = 8'h00;
        bus.addr = 16'h0003;
        bus.data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        checks++;
        if (bus.valid !== 1'b1 || bus.err !== 1'b1 || bus.data_out !== 64'h0) begin
            errors++;
            $display("FAIL err_misalign got v=%b e=%b d=%h want 1 1 0",
                     bus.valid, bus.err, bus.data_out);
        end
        bus.we = 1'b0;
        bus.addr = 16'h0000;
        tick();
        checks++;
        if (bus.err !== 1'b0 || bus.data_out !== W_A) begin
            errors++;
            $display("FAIL err_nochange got e=%b d=%h want 0 %h",
                     bus.err, bus.data_out, W_A);
        end
        bus.addr = 16'h0800;
        tick();
        checks++;
        if (bus.err !== 1'b1 || bus.data_out !== 64'h0) begin
            errors++;
            $display("FAIL err_range got e=%b d=%h want 1 0",
                     bus.err, bus.data_out);
        end
        idle();
        bus.b_en = 1'b1;
        bus.b_addr = 16'h0805;
        tick();
        checks++;
        if (bus.b_valid !== 1'b1 || bus.b_err !== 1'b1 ||
            bus.b_data_out !== 64'h0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL err_b got v=%b e=%b d=%h a_err=%b want 1 1 0 0",
                     bus.b_valid, bus.b_err, bus.b_data_out, bus.err);
        end
        idle();
        tick();
        checks++;
        if (bus.b_err !== 1'b0 || bus.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got v=%b e=%b want 0 0",
                     bus.b_valid, bus.b_err);
        end
    endtask

    task automatic test_forwarding();
        bus.en = 1'b1;
        bus.we = 1'b1;
        bus.ben_n = 8'h00;
        bus.addr = 16'h0020;
        bus.data_in = W_F;
        bus.b_en = 1'b1;
        bus.b_addr = 16'h0020;
        tick();
        checks++;
        if (bus.b_data_out !== W_F || bus.data_out !== W_F) begin
            errors++;
            $display("FAIL fwd got b=%h a=%h want %h", bus.b_data_out,
                     bus.data_out, W_F);
        end
        bus.we = 1'b0;
        bus.addr = 16'h0000;
        bus.b_addr = 16'h0010;
        tick();
        checks++;
        if (bus.data_out !== W_A || bus.b_data_out !== W_M) begin
            errors++;
            $display("FAIL dual_read got a=%h b=%h want %h %h",
                     bus.data_out, bus.b_data_out, W_A, W_M);
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        int cyc, pul;
        for (int i = 0; i < 2; i++) begin
            bus.en = 1'b1;
            bus.we = 1'b1;
            bus.ben_n = 8'h00;
            bus.addr = 16'(i * 8);
            bus.data_in = 64'h0123_4567_89AB_CDEF;
            tick();
        end
        bus.addr = 16'h0010;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL burst_reset got v=%b busy=%b want 0 1",
                     bus.valid, bus.busy);
        end
        reset = 1'b0;
        idle();
        count_busy(cyc, pul);
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL burst_clear_len got %0d want 256", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            bus.en = 1'b1;
            bus.addr = 16'(i * 8);
            bus.b_en = 1'b1;
            bus.b_addr = 16'(i * 8);
            tick();
            checks++;
            if (bus.data_out !== 64'h0 || bus.b_data_out !== 64'h0 ||
                bus.valid !== 1'b1) begin
                errors++;
                $display("FAIL burst_cleared[%0d] got a=%h b=%h v=%b want 0 0 1",
                         i, bus.data_out, bus.b_data_out, bus.valid);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int cyc, pul;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_busy got %b want 1", bus.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(cyc, pul);
        checks++;
        if (cyc != 256) begin
            errors++;
            $display("FAIL mid_clear_len got %0d want 256", cyc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        idle();
        tick();
        test_reset();
        test_clear_read();
        test_full_lane();
        test_byte_lanes();
        test_errors();
        test_forwarding();
        test_reset_mid_burst();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
